// File: rtl/seg7_scan_if.sv
// Register-side and pin-side signal bundle for the multiplexed 7-segment driver.
// The master drives frame data and the live blanking control; the slave drives the display pins.
interface seg7_scan_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   din;
    logic [3*DIGITS-1:0]   code;
    logic [DIGITS-1:0]     dots;
    logic                  lzb;
    logic [7:0]            seg;
    logic [DIGITS-1:0]     an;
    logic                  pend;
    logic                  frame;

    modport master (
        output load, din, code, dots, lzb,
        input  seg, an, pend, frame
    );

    modport slave (
        input  load, din, code, dots, lzb,
        output seg, an, pend, frame
    );
endinterface

// File: rtl/seg7_scan.sv
// Time-multiplexed N-digit common-anode 7-segment driver with double-buffered frame,
// per-slot anti-ghost blanking and leading-zero suppression.
module seg7_scan #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int BLANK  = 16
) (
    input  logic        clk,
    input  logic        reset,
    seg7_scan_if.slave  bus
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(DIGITS - 1);
    localparam logic [2:0]       CODE_NUM  = 3'd0;
    localparam logic [2:0]       CODE_BLK  = 3'd2;

    // Segment pattern {g,f,e,d,c,b,a}, 1 = lit, for a glyph code and hex value.
    function automatic logic [6:0] glyph_f(input logic [2:0] sel, input logic [3:0] val);
        logic [6:0] g;
        case (sel)
            3'd0: begin
                case (val)
                    4'h0:    g = 7'b0111111;
                    4'h1:    g = 7'b0000110;
                    4'h2:    g = 7'b1011011;
                    4'h3:    g = 7'b1001111;
                    4'h4:    g = 7'b1100110;
                    4'h5:    g = 7'b1101101;
                    4'h6:    g = 7'b1111101;
                    4'h7:    g = 7'b0000111;
                    4'h8:    g = 7'b1111111;
                    4'h9:    g = 7'b1100111;
                    4'hA:    g = 7'b1110111;
                    4'hB:    g = 7'b1111100;
                    4'hC:    g = 7'b0111001;
                    4'hD:    g = 7'b1011110;
                    4'hE:    g = 7'b1111001;
                    4'hF:    g = 7'b1110001;
                    default: g = 7'b0000000;
                endcase
            end
            3'd1:    g = 7'b1000000;
            3'd2:    g = 7'b0000000;
            3'd3:    g = 7'b1110110;
            3'd4:    g = 7'b0010000;
            3'd5:    g = 7'b0111000;
            3'd6:    g = 7'b1011100;
            default: g = 7'b0000000;
        endcase
        return g;
    endfunction

    logic [CNT_W-1:0]    cnt_r;
    logic [IDX_W-1:0]    idx_r;
    logic [4*DIGITS-1:0] act_din_r;
    logic [3*DIGITS-1:0] act_code_r;
    logic [DIGITS-1:0]   act_dots_r;
    logic [4*DIGITS-1:0] shd_din_r;
    logic [3*DIGITS-1:0] shd_code_r;
    logic [DIGITS-1:0]   shd_dots_r;
    logic                pend_r;
    logic                frame_r;
    logic [7:0]          seg_r;
    logic [DIGITS-1:0]   an_r;

    logic                wrap_s;
    logic                boundary_s;
    logic [DIGITS-1:0]   supp_s;
    logic                lead_s;
    logic                zero_num_s;
    logic [2:0]          cur_code_s;
    logic [3:0]          cur_din_s;
    logic                cur_dot_s;
    logic [6:0]          cur_glyph_s;
    logic [7:0]          seg_next_s;
    logic [DIGITS-1:0]   an_next_s;

    assign wrap_s     = (cnt_r == CNT_MAX);
    assign boundary_s = wrap_s && (idx_r == IDX_MAX);

    // Slot prescaler and digit index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
            idx_r <= '0;
        end else if (wrap_s) begin
            cnt_r <= '0;
            idx_r <= (idx_r == IDX_MAX) ? '0 : idx_r + IDX_W'(1);
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Shadow capture on load; shadow-to-active transfer only at the frame boundary.
    // A load on the boundary edge still sends the previous shadow to the active frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_din_r  <= '0;
            act_code_r <= {DIGITS{CODE_BLK}};
            act_dots_r <= '0;
            shd_din_r  <= '0;
            shd_code_r <= {DIGITS{CODE_BLK}};
            shd_dots_r <= '0;
            pend_r     <= 1'b0;
        end else begin
            if (boundary_s && pend_r) begin
                act_din_r  <= shd_din_r;
                act_code_r <= shd_code_r;
                act_dots_r <= shd_dots_r;
            end
            if (bus.load) begin
                shd_din_r  <= bus.din;
                shd_code_r <= bus.code;
                shd_dots_r <= bus.dots;
                pend_r     <= 1'b1;
            end else if (boundary_s) begin
                pend_r     <= 1'b0;
            end
        end
    end

    // Leading-zero suppression mask, walking from the most significant digit down.
    always_comb begin
        supp_s     = '0;
        lead_s     = 1'b1;
        zero_num_s = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_num_s = (act_code_r[3*i +: 3] == CODE_NUM) && (act_din_r[4*i +: 4] == 4'd0);
            if (i != 0) begin
                supp_s[i] = bus.lzb && lead_s && zero_num_s;
            end else begin
                supp_s[i] = 1'b0;
            end
            lead_s = lead_s && zero_num_s;
        end
    end

    // Pattern for the digit currently being scanned.
    always_comb begin
        cur_code_s  = act_code_r[3*int'(idx_r) +: 3];
        cur_din_s   = act_din_r[4*int'(idx_r) +: 4];
        cur_dot_s   = act_dots_r[idx_r];
        cur_glyph_s = glyph_f(cur_code_s, cur_din_s);
        if (supp_s[idx_r]) begin
            seg_next_s = ~{cur_dot_s, 7'b0000000};
        end else begin
            seg_next_s = ~{cur_dot_s, cur_glyph_s};
        end
        an_next_s = '1;
        if (cnt_r >= CNT_BLANK) begin
            an_next_s[idx_r] = 1'b0;
        end else begin
            an_next_s = '1;
        end
    end

    // Registered pin drivers and frame pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_r   <= 8'hFF;
            an_r    <= '1;
            frame_r <= 1'b0;
        end else begin
            seg_r   <= seg_next_s;
            an_r    <= an_next_s;
            frame_r <= boundary_s;
        end
    end

    assign bus.seg   = seg_r;
    assign bus.an    = an_r;
    assign bus.pend  = pend_r;
    assign bus.frame = frame_r;
endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan (DIGITS=4, DIV=8, BLANK=2): a time-based reference
// model is compared every cycle, plus directed literal expectations.
module tb_seg7_scan;
    localparam int D = 4;
    localparam int V = 8;
    localparam int B = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    seg7_scan_if #(.DIGITS(D)) bus();

    seg7_scan #(.DIGITS(D), .DIV(V), .BLANK(B)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference segment tables taken straight from the glyph definitions.
    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [6:0] sym_tab [8]  = '{7'h00, 7'h40, 7'h00, 7'h76, 7'h10, 7'h38, 7'h5C, 7'h00};

    // Model state: frames as per-digit arrays, time as cycles since reset release.
    logic [3:0] a_din [D];
    logic [2:0] a_code[D];
    logic       a_dot [D];
    logic [3:0] s_din [D];
    logic [2:0] s_code[D];
    logic       s_dot [D];
    logic       m_pend;
    int         t;
    logic [7:0] e_seg;
    logic [D-1:0] e_an;
    logic       e_pend;
    logic       e_frame;

    function automatic logic [6:0] shown(input int d, input logic lz);
        logic sup;
        sup = lz && (d != 0);
        for (int j = d; j < D; j++) begin
            if (!(a_code[j] == 3'd0 && a_din[j] == 4'd0)) sup = 1'b0;
        end
        if (sup) return 7'h00;
        if (a_code[d] == 3'd0) return hex_tab[a_din[d]];
        return sym_tab[a_code[d]];
    endfunction

    always @(posedge clk or posedge reset) begin
        int pos, di, ci;
        if (reset) begin
            for (int i = 0; i < D; i++) begin
                a_din[i] = 4'd0; a_code[i] = 3'd2; a_dot[i] = 1'b0;
                s_din[i] = 4'd0; s_code[i] = 3'd2; s_dot[i] = 1'b0;
            end
            m_pend = 1'b0; t = 0;
            e_seg = 8'hFF; e_an = '1; e_pend = 1'b0; e_frame = 1'b0;
        end else begin
            pos = t % (D * V);
            di  = pos / V;
            ci  = pos % V;
            e_an = '1;
            if (ci >= B) e_an[di] = 1'b0;
            e_seg   = ~{a_dot[di], shown(di, bus.lzb)};
            e_frame = (pos == D * V - 1);
            if (e_frame && m_pend) begin
                a_din = s_din; a_code = s_code; a_dot = s_dot;
                m_pend = 1'b0;
            end
            if (bus.load) begin
                for (int i = 0; i < D; i++) begin
                    s_din[i]  = bus.din[4*i +: 4];
                    s_code[i] = bus.code[3*i +: 3];
                    s_dot[i]  = bus.dots[i];
                end
                m_pend = 1'b1;
            end
            e_pend = m_pend;
            t++;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        checks++;
        if (bus.seg !== e_seg) begin
            errors++; $display("FAIL model_seg t=%0d actual=%h required=%h", t, bus.seg, e_seg);
        end
        checks++;
        if (bus.an !== e_an) begin
            errors++; $display("FAIL model_an t=%0d actual=%h required=%h", t, bus.an, e_an);
        end
        checks++;
        if (bus.pend !== e_pend) begin
            errors++; $display("FAIL model_pend t=%0d actual=%b required=%b", t, bus.pend, e_pend);
        end
        checks++;
        if (bus.frame !== e_frame) begin
            errors++; $display("FAIL model_frame t=%0d actual=%b required=%b", t, bus.frame, e_frame);
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk); n++;
        end while (!bus.frame && n < 100);
        if (!bus.frame) begin
            checks++; errors++;
            $display("FAIL wait_frame timeout actual=0 required=1");
        end
    endtask

    task automatic expect_digit(input int d, input logic [7:0] s, input string nm);
        logic [D-1:0] tgt;
        int n = 0;
        tgt = ~(4'b0001 << d);
        do begin
            @(negedge clk); n++;
        end while (bus.an !== tgt && n < 100);
        if (bus.an !== tgt) begin
            checks++; errors++;
            $display("FAIL %s anode timeout actual=%h required=%h", nm, bus.an, tgt);
        end else begin
            chk(nm, bus.seg, s);
        end
    endtask

    task automatic do_load(input logic [15:0] dv, input logic [11:0] cv, input logic [3:0] pv);
        @(negedge clk);
        bus.load = 1'b1; bus.din = dv; bus.code = cv; bus.dots = pv;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    initial begin
        int first_frame;
        int n;
        bus.load = 1'b0; bus.din = '0; bus.code = '0; bus.dots = '0; bus.lzb = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("reset_seg", bus.seg, 8'hFF);
        chk("reset_an", {4'h0, bus.an}, 8'h0F);
        chk("reset_pend", {7'd0, bus.pend}, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Blanking prefix, first lit slot and first frame pulse after reset.
        first_frame = -1;
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n <= 9) chk($sformatf("scan_an_c%0d", n), {4'h0, bus.an},
                            (n >= 3 && n <= 8) ? 8'h0E : 8'h0F);
            if (bus.frame && first_frame < 0) first_frame = n;
        end
        chk("first_frame_cycle", 8'(first_frame), 8'd32);

        // Mid-frame load held off until the boundary.
        do_load(16'h1234, 12'h000, 4'b0001);
        chk("load_pend", {7'd0, bus.pend}, 8'h01);
        wait_frame();
        expect_digit(0, 8'h19, "load_d0");
        chk("load_pend_clr", {7'd0, bus.pend}, 8'h00);
        expect_digit(3, 8'hF9, "load_d3");

        // Leading-zero blanking.
        bus.lzb = 1'b1;
        do_load(16'h0050, 12'h000, 4'b0000);
        wait_frame();
        expect_digit(0, 8'hC0, "lzb_d0");
        expect_digit(1, 8'h92, "lzb_d1");
        expect_digit(2, 8'hFF, "lzb_d2");
        expect_digit(3, 8'hFF, "lzb_d3");
        do_load(16'h0000, 12'h000, 4'b0000);
        wait_frame();
        expect_digit(0, 8'hC0, "lzb0_d0");
        expect_digit(1, 8'hFF, "lzb0_d1");
        expect_digit(3, 8'hFF, "lzb0_d3");
        bus.lzb = 1'b0;

        // Symbol glyphs H, i, L, o.
        do_load(16'h0000, {3'd6, 3'd5, 3'd4, 3'd3}, 4'b0000);
        wait_frame();
        expect_digit(0, 8'h89, "sym_d0");
        expect_digit(1, 8'hEF, "sym_d1");
        expect_digit(2, 8'hC7, "sym_d2");
        expect_digit(3, 8'hA3, "sym_d3");

        // Load on the boundary edge with an older load still pending.
        wait_frame();
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            if (k == 4) begin
                bus.load = 1'b1; bus.din = 16'h0007; bus.code = 12'h000; bus.dots = 4'b0000;
            end else if (k == 31) begin
                bus.load = 1'b1; bus.din = 16'h000A; bus.code = 12'h000; bus.dots = 4'b0000;
            end else begin
                bus.load = 1'b0;
            end
        end
        @(negedge clk);
        bus.load = 1'b0;
        chk("bnd_frame", {7'd0, bus.frame}, 8'h01);
        chk("bnd_pend", {7'd0, bus.pend}, 8'h01);
        expect_digit(0, 8'hF8, "bnd_old_d0");
        wait_frame();
        expect_digit(0, 8'h88, "bnd_new_d0");
        chk("bnd_pend_clr", {7'd0, bus.pend}, 8'h00);

        // Asynchronous reset mid-frame while digit 2 is lit.
        wait_frame();
        do_load(16'h5678, 12'h000, 4'b1111);
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (bus.an !== 4'hB && n < 100);
        chk("rst_pre_an", {4'h0, bus.an}, 8'h0B);
        chk("rst_pre_pend", {7'd0, bus.pend}, 8'h01);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_seg", bus.seg, 8'hFF);
        chk("rst_mid_an", {4'h0, bus.an}, 8'h0F);
        chk("rst_mid_pend", {7'd0, bus.pend}, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_restart_an", {4'h0, bus.an}, 8'h0E);
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
